// File: rtl/fft_128_out_buffer_pkg.sv
// Shared constants, output word layout and address helper for the FFT output buffer.
package fft_out_pkg;

  localparam int FFT_N  = 128;
  localparam int ADDR_W = 7;
  localparam int OW     = 24;
  localparam int DOUT_W = 48;

  // One streamed result word: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic [OW-1:0] re;
    logic [OW-1:0] im;
  } outWord_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rdState_t;

  // Mirror a 7-bit bin index (bit 0 becomes bit 6).
  function automatic logic [ADDR_W-1:0] bitrev7(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_128_out_buffer_sat_round.sv
// Per-component narrowing: optional round-half-up right shift, then clamp to 24-bit signed.
module fft_out_sat_round
  import fft_out_pkg::*;
#(
  parameter int IW    = 28,
  parameter int SHIFT = 0
) (
  input  logic signed [IW-1:0] x,
  output logic        [OW-1:0] y,
  output logic                 sat
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int VW = IW + 1;
  localparam logic signed [VW-1:0] MAX_V = VW'(2**(OW-1) - 1);
  localparam logic signed [VW-1:0] MIN_V = VW'(-(2**(OW-1)));

  logic signed [VW-1:0] xe;
  logic signed [VW-1:0] v;

  assign xe = {x[IW-1], x};

  generate
    if (SHIFT > 0) begin : gRound
      localparam logic signed [VW-1:0] HALF = VW'(2**(SHIFT-1));
      logic signed [VW-1:0] sum;
      assign sum = xe + HALF;
      assign v   = sum >>> SHIFT;
    end else begin : gPass
      assign v = xe;
    end
  endgenerate

  // Clamp to the 24-bit range and flag when clamping happened.
  always_comb begin
    y   = v[OW-1:0];
    sat = 1'b0;
    if (v > MAX_V) begin
      y   = {1'b0, {(OW-1){1'b1}}};
      sat = 1'b1;
    end else if (v < MIN_V) begin
      y   = {1'b1, {(OW-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fft_128_out_buffer.sv
// Double-buffered FFT result capture: the core fills one bank while the other streams out.
module fft_128_out_buffer
  import fft_out_pkg::*;
#(
  parameter int IW         = 28,
  parameter int SHIFT      = 0,
  parameter bit BITREV_OUT = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 WrEn,
  input  logic [ADDR_W-1:0]    WrAddr,
  input  logic signed [IW-1:0] WrR,
  input  logic signed [IW-1:0] WrI,
  input  logic                 FrameDone,
  output logic                 WrRdy,
  input  logic                 StallIn,
  output logic                 PushOut,
  output logic                 FirstOut,
  output logic [DOUT_W-1:0]    DataOut,
  output logic                 Overflow,
  output logic                 SatFlag
);

  localparam int MW = 2 * IW;

  // Both banks live in one array; the bank pointer is the top address bit.
  logic [MW-1:0]     mem [2*FFT_N];
  logic [MW-1:0]     rdReg;
  logic [1:0]        fullReg, fullNext;
  logic              wbReg, rbReg;
  logic [ADDR_W-1:0] raReg;
  logic [ADDR_W-1:0] rdAddr;
  rdState_t          stateReg, stateNext;
  logic              issue, lastIssue;
  logic              wrAccept, doneAccept;
  logic              pushReg, firstReg, ovfReg, satReg;
  logic [OW-1:0]     compY [2];
  logic [1:0]        compSat;
  outWord_t          word;

  assign WrRdy      = ~fullReg[wbReg];
  assign wrAccept   = WrEn & WrRdy;
  assign doneAccept = FrameDone & WrRdy;

  generate
    if (BITREV_OUT) begin : gRev
      assign rdAddr = bitrev7(raReg);
    end else begin : gNat
      assign rdAddr = raReg;
    end
  endgenerate

  // Write port: accepted bins land in the bank currently owned by the core.
  always_ff @(posedge Clk) begin
    if (wrAccept) begin
      mem[{wbReg, WrAddr}] <= {WrR, WrI};
    end
  end

  // Read FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Next state looks at next-cycle bank flags so a just-completed frame starts without a bubble.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (fullNext[rbReg]) stateNext = STREAM;
      STREAM:  if (lastIssue && !fullNext[~rbReg]) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs: issue a read every unstalled streaming cycle.
  always_comb begin
    issue     = (stateReg == STREAM) && !StallIn;
    lastIssue = issue && (raReg == ADDR_W'(FFT_N - 1));
  end

  // Bank flags: a completed frame and a freed bank always refer to different banks.
  always_comb begin
    fullNext = fullReg;
    if (doneAccept) fullNext[wbReg] = 1'b1;
    if (lastIssue)  fullNext[rbReg] = 1'b0;
  end

  // Bank pointers, flags and read address; ra wraps to 0 after the last bin.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fullReg <= 2'b00;
      wbReg   <= 1'b0;
      rbReg   <= 1'b0;
      raReg   <= '0;
    end else begin
      fullReg <= fullNext;
      if (doneAccept) wbReg <= ~wbReg;
      if (lastIssue)  rbReg <= ~rbReg;
      if (issue)      raReg <= raReg + 1'b1;
    end
  end

  // Registered read port; it holds between reads so DataOut holds too.
  always_ff @(posedge Clk) begin
    if (Reset)      rdReg <= '0;
    else if (issue) rdReg <= mem[{rbReg, rdAddr}];
  end

  // Index 0 narrows the imaginary half, index 1 the real half.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gComp
      fft_out_sat_round #(
        .IW    (IW),
        .SHIFT (SHIFT)
      ) uSat (
        .x   (rdReg[gi*IW +: IW]),
        .y   (compY[gi]),
        .sat (compSat[gi])
      );
    end
  endgenerate

  // Push/first strobes track the read one cycle later; error flags are sticky until reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pushReg  <= 1'b0;
      firstReg <= 1'b0;
      ovfReg   <= 1'b0;
      satReg   <= 1'b0;
    end else begin
      pushReg  <= issue;
      firstReg <= issue && (raReg == '0);
      ovfReg   <= ovfReg | ((WrEn | FrameDone) & ~WrRdy);
      satReg   <= satReg | (pushReg & (compSat[0] | compSat[1]));
    end
  end

  assign word.re  = compY[1];
  assign word.im  = compY[0];
  assign DataOut  = word;
  assign PushOut  = pushReg;
  assign FirstOut = firstReg;
  assign Overflow = ovfReg;
  assign SatFlag  = satReg;

endmodule

// File: tb/tb_fft_128_out_buffer.sv
// Bench for the FFT output buffer: two instances (natural/no shift and bit-reversed/shift 2)
// share one stimulus and are checked every cycle against a frame-queue model.
module tb_fft_128_out_buffer;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              WrEn = 1'b0;
  logic [6:0]        WrAddr = '0;
  logic signed [27:0] WrR = '0;
  logic signed [27:0] WrI = '0;
  logic              FrameDone = 1'b0;
  logic              StallIn = 1'b0;

  logic        wrRdy0, push0, first0, ovf0, sat0;
  logic [47:0] data0;
  logic        wrRdy1, push1, first1, ovf1, sat1;
  logic [47:0] data1;

  always #5 Clk = ~Clk;

  fft_128_out_buffer #(.IW(28), .SHIFT(0), .BITREV_OUT(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrR(WrR), .WrI(WrI),
    .FrameDone(FrameDone), .WrRdy(wrRdy0), .StallIn(StallIn), .PushOut(push0),
    .FirstOut(first0), .DataOut(data0), .Overflow(ovf0), .SatFlag(sat0)
  );

  fft_128_out_buffer #(.IW(28), .SHIFT(2), .BITREV_OUT(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrR(WrR), .WrI(WrI),
    .FrameDone(FrameDone), .WrRdy(wrRdy1), .StallIn(StallIn), .PushOut(push1),
    .FirstOut(first1), .DataOut(data1), .Overflow(ovf1), .SatFlag(sat1)
  );

  int testsRun = 0;
  int testsFailed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: completed frames wait in a queue, the head one streams ----------------
  typedef int frame_t [128];
  frame_t qRe[$];
  frame_t qIm[$];
  frame_t fillRe;
  frame_t fillIm;
  int     idx = 0;
  int     cycleCnt = 0;
  int     lastFd = 0;
  logic        expPush = 1'b0, expFirst = 1'b0, expWrRdy = 1'b1, expOvf = 1'b0;
  logic [47:0] expData [2];
  logic        expPushSat [2];
  logic        expSat [2];

  logic        capEn = 1'b0;
  logic        lowSeen = 1'b0;
  int          capCycle[$];
  logic [47:0] cap0[$];
  logic [47:0] cap1[$];

  function automatic int bitrev(input int a);
    int r = 0;
    for (int i = 0; i < 7; i++) if (((a >> i) & 1) != 0) r |= (1 << (6 - i));
    return r;
  endfunction

  // Round-half-up shift then clamp to 24-bit signed, in plain integer arithmetic.
  function automatic logic [23:0] conv(input int x, input int sh, output logic sat);
    longint v;
    logic [63:0] vb;
    v = x;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    sat = (v > 64'sd8388607) || (v < -64'sd8388608);
    if (v > 64'sd8388607) return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    vb = v;
    return vb[23:0];
  endfunction

  function automatic int reOf(input logic [47:0] w);
    return int'($signed(w[47:24]));
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      expData[d] = '0;
      expPushSat[d] = 1'b0;
      expSat[d] = 1'b0;
    end
  end

  always @(posedge Clk) begin : modelProc
    frame_t curRe, curIm;
    int bin, sh;
    logic sR, sI;
    logic [23:0] yr, yi;
    bit rdy;
    cycleCnt++;
    if (FrameDone) lastFd = cycleCnt;
    if (Reset) begin
      qRe.delete();
      qIm.delete();
      idx = 0;
      expPush = 1'b0;
      expFirst = 1'b0;
      expOvf = 1'b0;
      for (int d = 0; d < 2; d++) begin
        expData[d] = '0;
        expPushSat[d] = 1'b0;
        expSat[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) expSat[d] = expSat[d] | (expPush & expPushSat[d]);
      rdy = (qRe.size() < 2);
      if ((WrEn || FrameDone) && !rdy) expOvf = 1'b1;
      if (!StallIn && qRe.size() > 0) begin
        curRe = qRe[0];
        curIm = qIm[0];
        expPush = 1'b1;
        expFirst = (idx == 0);
        for (int d = 0; d < 2; d++) begin
          bin = (d == 1) ? bitrev(idx) : idx;
          sh = (d == 1) ? 2 : 0;
          yr = conv(curRe[bin], sh, sR);
          yi = conv(curIm[bin], sh, sI);
          expData[d] = {yr, yi};
          expPushSat[d] = sR | sI;
        end
        idx++;
        if (idx == 128) begin
          idx = 0;
          void'(qRe.pop_front());
          void'(qIm.pop_front());
        end
      end else begin
        expPush = 1'b0;
        expFirst = 1'b0;
      end
      if (WrEn && rdy) begin
        fillRe[WrAddr] = WrR;
        fillIm[WrAddr] = WrI;
      end
      if (FrameDone && rdy) begin
        qRe.push_back(fillRe);
        qIm.push_back(fillIm);
      end
    end
    expWrRdy = (qRe.size() < 2);
    #1;
    check("push0", push0, expPush);
    check("push1", push1, expPush);
    check("first0", first0, expFirst);
    check("first1", first1, expFirst);
    check("data0", data0, expData[0]);
    check("data1", data1, expData[1]);
    check("wrrdy0", wrRdy0, expWrRdy);
    check("wrrdy1", wrRdy1, expWrRdy);
    check("ovf0", ovf0, expOvf);
    check("ovf1", ovf1, expOvf);
    check("sat0", sat0, expSat[0]);
    check("sat1", sat1, expSat[1]);
    if (capEn) begin
      if (!wrRdy0) lowSeen = 1'b1;
      if (push0) begin
        // Outputs seen just after edge n belong to the cycle that ends at edge n+1.
        capCycle.push_back(cycleCnt + 1);
        cap0.push_back(data0);
        cap1.push_back(data1);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int rawRe(input int base, input int mode, input int k);
    if (mode == 1) begin
      if (k == 0)  return 134217727;
      if (k == 64) return 6;
      if (k == 32) return -6;
      if (k == 96) return 5;
      return k;
    end
    return base + k;
  endfunction

  task automatic writeFrame(input int base, input int mode, input int stallCycles, input bit fdWithLast);
    for (int k = 0; k < 128; k++) begin
      WrEn = 1'b1;
      WrAddr = 7'(k);
      WrR = 28'(rawRe(base, mode, k));
      WrI = 28'(-k);
      StallIn = (k < stallCycles);
      FrameDone = fdWithLast && (k == 127);
      @(negedge Clk);
    end
    WrEn = 1'b0;
    FrameDone = 1'b0;
  endtask

  task automatic pulseFrameDone(input bit stall);
    FrameDone = 1'b1;
    StallIn = stall;
    @(negedge Clk);
    FrameDone = 1'b0;
  endtask

  task automatic clearCap();
    capCycle.delete();
    cap0.delete();
    cap1.delete();
    lowSeen = 1'b0;
  endtask

  task automatic waitWords(input int n, input int budget);
    int c = 0;
    while (cap0.size() < n && c < budget) begin
      @(negedge Clk);
      c++;
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_wrrdy", wrRdy0, 1'b1);
    check("reset_push", push0, 1'b0);
    check("reset_data", data0, 48'h0);
    capEn = 1'b1;

    // Single frame, natural data k / -k.
    clearCap();
    writeFrame(0, 0, 0, 1'b0);
    pulseFrameDone(1'b0);
    waitWords(128, 400);
    repeat (20) @(negedge Clk);
    $display("[TB] single frame: %0d words", cap0.size());
    check("t1_count", cap0.size(), 128);
    if (cap0.size() >= 128) begin
      check("t1_latency", capCycle[0] - lastFd, 2);
      check("t1_contig", capCycle[127] - capCycle[0], 127);
      check("t1_word5", cap0[5], 48'h000005_FFFFFB);
      check("t1_rev0", reOf(cap1[0]), 0);
      check("t1_rev1", reOf(cap1[1]), 16);
      check("t1_rev2", reOf(cap1[2]), 8);
      check("t1_rev3", reOf(cap1[3]), 24);
    end

    // Back-to-back: second frame completes while the first is still streaming.
    clearCap();
    writeFrame(0, 0, 0, 1'b0);
    pulseFrameDone(1'b1);
    writeFrame(1000, 0, 10, 1'b1);
    StallIn = 1'b0;
    waitWords(256, 600);
    repeat (20) @(negedge Clk);
    $display("[TB] back-to-back: %0d words", cap0.size());
    check("t2_count", cap0.size(), 256);
    check("t2_wrrdy_low", lowSeen, 1'b1);
    if (cap0.size() >= 256) begin
      check("t2_contig", capCycle[255] - capCycle[0], 255);
      check("t2_word128", reOf(cap0[128]), 1000);
    end

    // Stall on streaming cycles 10..14.
    clearCap();
    writeFrame(2000, 0, 0, 1'b0);
    pulseFrameDone(1'b0);
    repeat (10) @(negedge Clk);
    StallIn = 1'b1;
    repeat (5) @(negedge Clk);
    StallIn = 1'b0;
    waitWords(128, 400);
    repeat (20) @(negedge Clk);
    $display("[TB] stall: %0d words", cap0.size());
    check("t3_count", cap0.size(), 128);
    if (cap0.size() >= 128) begin
      check("t3_span", capCycle[127] - capCycle[0], 132);
      check("t3_word10", reOf(cap0[10]), 2010);
      check("t3_word127", reOf(cap0[127]), 2127);
    end

    // Overflow: three frames with the output held.
    clearCap();
    writeFrame(3000, 0, 1000, 1'b0);
    pulseFrameDone(1'b1);
    writeFrame(4000, 0, 1000, 1'b0);
    pulseFrameDone(1'b1);
    check("t4_wrrdy0", wrRdy0, 1'b0);
    check("t4_wrrdy1", wrRdy1, 1'b0);
    writeFrame(5000, 0, 1000, 1'b0);
    pulseFrameDone(1'b1);
    check("t4_ovf0", ovf0, 1'b1);
    check("t4_ovf1", ovf1, 1'b1);
    check("t4_held", cap0.size(), 0);
    StallIn = 1'b0;
    waitWords(256, 600);
    repeat (150) @(negedge Clk);
    $display("[TB] overflow: %0d words", cap0.size());
    check("t4_count", cap0.size(), 256);
    if (cap0.size() >= 256) begin
      check("t4_word0", reOf(cap0[0]), 3000);
      check("t4_word128", reOf(cap0[128]), 4000);
      check("t4_word255", reOf(cap0[255]), 4127);
    end

    // Saturation and rounding (dut1 shifts by 2 and emits bins 0,64,32,96 first).
    check("t5_sat_before", sat1, 1'b0);
    clearCap();
    writeFrame(0, 1, 0, 1'b0);
    pulseFrameDone(1'b0);
    waitWords(128, 400);
    repeat (5) @(negedge Clk);
    $display("[TB] saturation: %0d words", cap0.size());
    check("t5_count", cap0.size(), 128);
    if (cap0.size() >= 4) begin
      check("t5_sat_re", cap1[0], 48'h7FFFFF_000000);
      check("t5_rnd6", reOf(cap1[1]), 2);
      check("t5_rndm6", reOf(cap1[2]), -1);
      check("t5_rnd5", reOf(cap1[3]), 1);
      check("t5_nat_sat", reOf(cap0[0]), 8388607);
    end
    check("t5_satflag0", sat0, 1'b1);
    check("t5_satflag1", sat1, 1'b1);

    // Reset in the middle of a frame.
    clearCap();
    writeFrame(6000, 0, 0, 1'b0);
    pulseFrameDone(1'b0);
    waitWords(40, 200);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("t6_push", push0, 1'b0);
    check("t6_data", data0, 48'h0);
    check("t6_wrrdy", wrRdy0, 1'b1);
    check("t6_ovf", ovf0, 1'b0);
    clearCap();
    repeat (200) @(negedge Clk);
    $display("[TB] reset mid-stream: %0d words after reset", cap0.size());
    check("t6_silent", cap0.size(), 0);

    // Recovery: a fresh frame streams normally.
    clearCap();
    writeFrame(7000, 0, 0, 1'b0);
    pulseFrameDone(1'b0);
    waitWords(128, 400);
    repeat (10) @(negedge Clk);
    $display("[TB] post-reset frame: %0d words", cap0.size());
    check("t7_count", cap0.size(), 128);
    if (cap0.size() >= 1) check("t7_word0", reOf(cap0[0]), 7000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
